// File: rtl/display_scan.sv
// display_scan -- HUB75 LED panel scanner with binary-coded modulation.
//
// For every row, each of the 8 bit planes is handled in three steps. The
// plane's bit is shifted out serially for all columns. The bits are then
// latched and the row address is updated. Finally the row is lit for
// BASE_TIME << plane cycles. Reads go to an external display memory that
// returns data one cycle after the address. A pending swap request toggles
// the buffer select at frame end.
//
// Optional feature: define DISPLAY_SCAN_GAMMA_EN to square each channel
// ((c*c)>>8) before bit-plane selection. This is combinational and adds no
// latency.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   enable          run request, sampled in IDLE and at frame end
//   swap_req        single-cycle buffer swap request (sticky until frame end)
//   flip            display memory buffer select
//   rrow, rcol      display memory read address
//   rdata           pixel {r,g,b} valid one cycle after rrow/rcol
//   panel_clk       HUB75 shift clock
//   panel_lat       HUB75 latch
//   panel_oe_n      HUB75 output enable, active low
//   panel_addr      HUB75 row select
//   panel_rgb       HUB75 serial colour bits
//   frame_done      one-cycle pulse in the first cycle after a frame
//   state_o         FSM state, for debug and checkers
//
// Request semantics: swap_req has no ready. Any cycle with swap_req=1 sets
// the pending flag. The flag is consumed at the next frame end, in the same
// cycle that frame_done is high.
module display_scan #(
  parameter int ROWS      = 8,
  parameter int COLUMNS   = 32,
  parameter int BASE_TIME = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       swap_req,
  output logic                       flip,
  output logic [$clog2(ROWS)-1:0]    rrow,
  output logic [$clog2(COLUMNS)-1:0] rcol,
  input  logic [23:0]                rdata,
  output logic                       panel_clk,
  output logic                       panel_lat,
  output logic                       panel_oe_n,
  output logic [$clog2(ROWS)-1:0]    panel_addr,
  output logic [2:0]                 panel_rgb,
  output logic                       frame_done,
  output logic [1:0]                 state_o
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLUMNS);
  // The shift phase runs steps 0..2*COLUMNS+1. Step 2k presents column k.
  // Step 2k+1 captures column k. That capture is driven at step 2k+2
  // (clock low) and clocked at step 2k+3 (clock high).
  localparam int SW = $clog2(2 * COLUMNS + 2);
  localparam int TW = $clog2(BASE_TIME * 128);

  localparam logic [SW-1:0] LAST_STEP = SW'(2 * COLUMNS + 1);
  localparam logic [SW-1:0] LAST_CAP  = SW'(2 * COLUMNS - 1);
  localparam logic [SW-1:0] FIRST_CLK = SW'(3);
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SHIFT   = 2'd1;
  localparam logic [1:0] LATCH   = 2'd2;
  localparam logic [1:0] DISPLAY = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [2:0]    plane_q, plane_d;
  logic [RW-1:0] row_q, row_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] addr_q, addr_d;
  logic [2:0]    rgb_q, rgb_d;
  logic          pending_q, pending_d;
  logic          flip_q, flip_d;
  logic          done_q, done_d;
  logic          frame_end;
  logic          swap_now;
  logic [7:0]    ch_r, ch_g, ch_b;

  function automatic logic [7:0] shape(input logic [7:0] c);
`ifdef DISPLAY_SCAN_GAMMA_EN
    logic [15:0] sq;
    sq = 16'(c) * 16'(c);
    return sq[15:8];
`else
    return c;
`endif
  endfunction

  assign ch_r = shape(rdata[23:16]);
  assign ch_g = shape(rdata[15:8]);
  assign ch_b = shape(rdata[7:0]);

  assign swap_now = pending_q | swap_req;

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    plane_d   = plane_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rgb_d     = rgb_q;
    frame_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SHIFT;
          step_d  = '0;
          row_d   = '0;
          plane_d = '0;
        end
      end
      SHIFT: begin
        if (step_q[0] && step_q <= LAST_CAP) begin
          rgb_d = {ch_r[plane_q], ch_g[plane_q], ch_b[plane_q]};
        end
        if (step_q == LAST_STEP) begin
          state_d = LATCH;
          step_d  = '0;
          // Row select changes only while the panel is dark.
          addr_d  = row_q;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      LATCH: begin
        state_d = DISPLAY;
        cnt_d   = TW'((BASE_TIME << plane_q) - 1);
      end
      default: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (plane_q != 3'd7) begin
          plane_d = plane_q + 1'b1;
          state_d = SHIFT;
        end else begin
          plane_d = '0;
          if (row_q == LAST_ROW) begin
            frame_end = 1'b1;
            row_d     = '0;
            state_d   = enable ? SHIFT : IDLE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = SHIFT;
          end
        end
      end
    endcase
  end

  // A request arriving in the cycle that detects frame end still belongs to
  // the ending frame. A request in the frame_done cycle waits for the next frame.
  assign pending_d = frame_end ? 1'b0 : swap_now;
  assign flip_d    = frame_end ? (flip_q ^ swap_now) : flip_q;
  assign done_d    = frame_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      step_q    <= '0;
      plane_q   <= '0;
      row_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      rgb_q     <= '0;
      pending_q <= 1'b0;
      flip_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      plane_q   <= plane_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rgb_q     <= rgb_d;
      pending_q <= pending_d;
      flip_q    <= flip_d;
      done_q    <= done_d;
    end
  end

  assign rrow       = row_q;
  assign rcol       = step_q[CW:1];
  assign panel_clk  = (state_q == SHIFT) && step_q[0] && (step_q >= FIRST_CLK);
  assign panel_lat  = (state_q == LATCH);
  assign panel_oe_n = (state_q != DISPLAY);
  assign panel_addr = addr_q;
  assign panel_rgb  = rgb_q;
  assign flip       = flip_q;
  assign frame_done = done_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan -- randomized self-checking bench for display_scan.
// A memory model answers reads one cycle late. For each frame, the reference
// model builds the expected stream of panel events from the pixel contents:
// shifted bits, latch addresses and lit durations. A monitor process compares
// the panel pins against that stream.
module tb_display_scan;
  localparam int ROWS      = 8;
  localparam int COLUMNS   = 32;
  localparam int BASE_TIME = 1;
  localparam int RW        = $clog2(ROWS);
  localparam int CW        = $clog2(COLUMNS);

  logic          clk;
  logic          rst;
  logic          enable;
  logic          swap_req;
  logic          flip;
  logic [RW-1:0] rrow;
  logic [CW-1:0] rcol;
  logic [23:0]   rdata;
  logic          panel_clk;
  logic          panel_lat;
  logic          panel_oe_n;
  logic [RW-1:0] panel_addr;
  logic [2:0]    panel_rgb;
  logic          frame_done;
  logic [1:0]    state_o;

  display_scan #(.ROWS(ROWS), .COLUMNS(COLUMNS), .BASE_TIME(BASE_TIME)) dut (
    .clk(clk), .rst(rst), .enable(enable), .swap_req(swap_req), .flip(flip),
    .rrow(rrow), .rcol(rcol), .rdata(rdata), .panel_clk(panel_clk),
    .panel_lat(panel_lat), .panel_oe_n(panel_oe_n), .panel_addr(panel_addr),
    .panel_rgb(panel_rgb), .frame_done(frame_done), .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // display memory: synchronous read, one cycle latency
  logic [23:0] mem [ROWS][COLUMNS];
  always @(posedge clk) rdata <= mem[rrow][rcol];

  // scoreboard
  logic [2:0] exp_q[$];
  int         exp_oe_q[$];
  int         exp_addr_q[$];
  int         total = 0;
  int         bad = 0;
  bit         mon_en = 1'b0;
  int         edge_total = 0, oe_low_total = 0, fd_total = 0, lat_total = 0;
  int         lit_cnt[8];
  logic [7:0] lit_mask;
  int         lit_sum;
  logic       cur_flip = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: channel shaping, then bit-plane selection
  function automatic int shape(input int c);
`ifdef DISPLAY_SCAN_GAMMA_EN
    return (c * c) / 256;
`else
    return c;
`endif
  endfunction

  function automatic logic [2:0] plane_bits(input logic [23:0] pix, input int p);
    int r, g, b;
    r = shape(int'(pix[23:16]));
    g = shape(int'(pix[15:8]));
    b = shape(int'(pix[7:0]));
    return {1'((r >> p) & 1), 1'((g >> p) & 1), 1'((b >> p) & 1)};
  endfunction

  task automatic build_expect();
    for (int r = 0; r < ROWS; r++) begin
      for (int p = 0; p < 8; p++) begin
        for (int c = 0; c < COLUMNS; c++) exp_q.push_back(plane_bits(mem[r][c], p));
        exp_addr_q.push_back(r);
        exp_oe_q.push_back(BASE_TIME << p);
      end
    end
  endtask

  task automatic fill_mem(input int kind);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLUMNS; c++) begin
        case (kind)
          0:       mem[r][c] = 24'hFFFFFF;
          1:       mem[r][c] = (r == 2 && c == 5) ? 24'h800000 : 24'h000000;
          2:       mem[r][c] = 24'h101010;
          default: mem[r][c] = 24'($urandom);
        endcase
      end
    end
  endtask

  // driver: one frame with optional swap pulses and enable drop
  task automatic run_frame(input int kind, input int swap0, input int swap1,
                           input int drop_at, input logic exp_flip, input bit swap_first);
    int   cyc;
    bit   done;
    logic pre_flip;
    int   snap[8];
    fill_mem(kind);
    build_expect();
    for (int i = 0; i < 8; i++) snap[i] = lit_cnt[i];
    enable = 1'b1;
    swap_req = swap_first;
    cyc = 0;
    done = 1'b0;
    pre_flip = flip;
    while (!done && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      swap_req = (cyc == swap0 || cyc == swap1);
      if (cyc == drop_at) enable = 1'b0;
      if (frame_done) done = 1'b1;
      else pre_flip = flip;
    end
    swap_req = 1'b0;
    check("frame_timeout", 32'(done), 32'd1);
    check("flip_before_done", 32'(pre_flip), 32'(cur_flip));
    check("flip_at_done", 32'(flip), 32'(exp_flip));
    cur_flip = exp_flip;
    #1;
    check("pix_left", exp_q.size(), 0);
    check("addr_left", exp_addr_q.size(), 0);
    check("oe_left", exp_oe_q.size(), 0);
    lit_mask = '0;
    lit_sum = 0;
    for (int i = 0; i < 8; i++) begin
      lit_mask[i] = (lit_cnt[i] != snap[i]);
      lit_sum += lit_cnt[i] - snap[i];
    end
  endtask

  // monitor: compares panel pins with the expected event stream
  task automatic monitor();
    logic       prev_clk = 1'b0, prev_oe = 1'b1;
    logic [RW-1:0] prev_addr = '0;
    logic [2:0] prev_rgb = '0;
    int edge_cnt = 0, oe_run = 0, run_idx = 0, row_sum = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (panel_clk && !prev_clk) begin
          edge_total++;
          edge_cnt++;
          if (panel_rgb != 3'b000) lit_cnt[lat_total % 8]++;
          if (exp_q.size() == 0) check("pix_extra", 32'd1, 32'd0);
          else check("pix", 32'(panel_rgb), 32'(exp_q.pop_front()));
        end
        if (panel_clk) check("rgb_hold_clk_high", 32'(panel_rgb), 32'(prev_rgb));
        if (panel_lat) begin
          check("lat_cols", edge_cnt, COLUMNS);
          check("lat_oe_n", 32'(panel_oe_n), 32'd1);
          edge_cnt = 0;
          lat_total++;
          if (exp_addr_q.size() == 0) check("lat_extra", 32'd1, 32'd0);
          else check("lat_addr", 32'(panel_addr), 32'(exp_addr_q.pop_front()));
        end
        if (!panel_oe_n) begin
          oe_run++;
          oe_low_total++;
          if (!prev_oe) check("addr_hold_oe_low", 32'(panel_addr), 32'(prev_addr));
        end else if (!prev_oe) begin
          if (exp_oe_q.size() == 0) check("oe_extra", 32'd1, 32'd0);
          else check("oe_len", oe_run, exp_oe_q.pop_front());
          row_sum += oe_run;
          oe_run = 0;
          run_idx++;
          if (run_idx == 8) begin
            check("row_oe_total", row_sum, BASE_TIME * 255);
            run_idx = 0;
            row_sum = 0;
          end
        end
        if (frame_done) fd_total++;
      end
      prev_clk  = panel_clk;
      prev_oe   = panel_oe_n;
      prev_addr = panel_addr;
      prev_rgb  = panel_rgb;
    end
  endtask

  initial begin
    int e0, o0, f0, cyc;
    for (int i = 0; i < 8; i++) lit_cnt[i] = 0;
    rst = 1'b1;
    enable = 1'b0;
    swap_req = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLUMNS; c++) mem[r][c] = '0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_flip", 32'(flip), 32'd0);
    check("rst_rrow", 32'(rrow), 32'd0);
    check("rst_rcol", 32'(rcol), 32'd0);
    check("rst_addr", 32'(panel_addr), 32'd0);
    check("rst_rgb", 32'(panel_rgb), 32'd0);
    check("rst_clk", 32'(panel_clk), 32'd0);
    check("rst_lat", 32'(panel_lat), 32'd0);
    check("rst_oe_n", 32'(panel_oe_n), 32'd1);
    check("rst_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_enable", 32'(state_o), 32'd0);
    fork
      monitor();
    join_none
    mon_en = 1'b1;

    // all white: every bit of every plane set
    run_frame(0, -1, -1, -1, 1'b0, 1'b0);
    check("white_planes", 32'(lit_mask), 32'hFF);
    check("white_edges", lit_sum, ROWS * 8 * COLUMNS);

    // single red MSB pixel at row 2, col 5
    run_frame(1, -1, -1, -1, 1'b0, 1'b0);
    check("pixel_lit_count", lit_sum, 1);
    check("pixel_plane", 32'(lit_mask), 32'h80);

    // uniform 0x101010, swap mid-frame
    run_frame(2, 1000, -1, -1, 1'b1, 1'b0);
`ifdef DISPLAY_SCAN_GAMMA_EN
    check("dim_plane", 32'(lit_mask), 32'h01);
`else
    check("dim_plane", 32'(lit_mask), 32'h10);
`endif

    // random frame, no request: flip holds
    run_frame(3, -1, -1, -1, 1'b1, 1'b0);
    // request in the frame_done cycle plus repeats: a single toggle
    run_frame(3, 500, 3000, -1, 1'b0, 1'b1);
    // random frame with swap and enable dropped mid-frame
    run_frame(3, 1500, -1, 2000, 1'b1, 1'b0);

    e0 = edge_total;
    o0 = oe_low_total;
    f0 = fd_total;
    repeat (100) @(negedge clk);
    check("drop_idle_state", 32'(state_o), 32'd0);
    check("drop_oe_n", 32'(panel_oe_n), 32'd1);
    check("drop_no_edges", edge_total - e0, 0);
    check("drop_no_oe", oe_low_total - o0, 0);
    check("drop_no_done", fd_total - f0, 0);

    // reset while the row is lit
    mon_en = 1'b0;
    enable = 1'b1;
    cyc = 0;
    while (panel_oe_n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_display", 32'(panel_oe_n), 32'd0);
    check("flip_before_rst", 32'(flip), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_oe_n", 32'(panel_oe_n), 32'd1);
    check("mid_rst_lat", 32'(panel_lat), 32'd0);
    check("mid_rst_rgb", 32'(panel_rgb), 32'd0);
    check("mid_rst_flip", 32'(flip), 32'd0);
    check("mid_rst_state", 32'(state_o), 32'd0);
    check("mid_rst_clk", 32'(panel_clk), 32'd0);
    check("mid_rst_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter: ROWS, 8, panel rows scanned; also the depth of the display memory.
REQ-002 Parameter: COLUMNS, 32, pixels shifted per row.
REQ-003 Parameter: BASE_TIME, 4, output-enable cycles for bit plane 0.
REQ-004 Port: clk  in  1  system clock; all logic on its rising edge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Port: enable  in  1  scan run request.
REQ-007 Port: swap_req  in  1  single-cycle request to swap display buffers.
REQ-008 Port: flip  out  1  buffer select to display memory.
REQ-009 Port: rrow  out  clog2(ROWS)  display memory read row.
REQ-010 Port: rcol  out  clog2(COLUMNS)  display memory read column.
REQ-011 Port: rdata  in  24  pixel read back one cycle after rrow/rcol, formatted {r[7:0],g[7:0],b[7:0]}.
REQ-012 Port: panel_clk, panel_lat, panel_oe_n  out  1 each  HUB75 shift clock, latch and active-low output enable.
REQ-013 Port: panel_addr  out  clog2(ROWS)  HUB75 row select.
REQ-014 Port: panel_rgb  out  3  {r,g,b} serial data bits.
REQ-015 Port: frame_done  out  1  one-cycle pulse at end of each frame.

Function
REQ-016 States: IDLE, SHIFT, LATCH, DISPLAY. A frame scans rows 0..ROWS-1; for each row it scans planes 0..7.
REQ-017 IDLE leaves for SHIFT (row 0, plane 0) when enable=1.
REQ-018 SHIFT, per column k: drive rcol=k and rrow=row; register panel_rgb[2:0] = {r[p],g[p],b[p]} from rdata for the current plane p; hold it 2 cycles, panel_clk 0 then 1.
REQ-019 panel_rgb changes only on cycles where panel_clk=0; each plane produces exactly COLUMNS rising edges of panel_clk.
REQ-020 In LATCH (1 cycle): panel_lat=1, panel_oe_n=1, panel_addr updates to the current row.
REQ-021 In DISPLAY: panel_oe_n=0 for exactly BASE_TIME<<p cycles; panel_oe_n=1 in all other states.
REQ-022 After DISPLAY, advance the plane; after plane 7, advance the row with plane 0; after row ROWS-1 plane 7, the frame ends.
REQ-023 swap_req sets a sticky pending flag; extra requests while pending have no further effect.
REQ-024 At frame end, if pending: toggle flip and clear pending in the same cycle that frame_done=1.
REQ-025 A swap_req in the frame-end cycle is applied at the following frame end.
REQ-026 At frame end, return to SHIFT row 0 if enable=1, else go to IDLE.
REQ-027 Deasserting enable mid-frame does not truncate the frame.
REQ-028 panel_addr never changes while panel_oe_n=0.

Reset
REQ-029 With rst=1 at a clk edge, the next cycle has:
- state=IDLE, pending=0, flip=0;
- rrow=0, rcol=0, panel_addr=0, panel_rgb=0;
- panel_clk=0, panel_lat=0, panel_oe_n=1, frame_done=0.
REQ-030 Reset mid-operation (any state) aborts the frame immediately with the values of REQ-029; the flip value is not preserved.

Configuration
REQ-031 Macro DISPLAY_SCAN_GAMMA_EN: when defined, each 8-bit channel c is replaced by (c*c)>>8, computed 16-bit and truncated to 8 bits, before plane bit selection; this adds no latency.
REQ-032 When DISPLAY_SCAN_GAMMA_EN is undefined, channels are used unmodified.

Verification (ROWS=8, COLUMNS=32, BASE_TIME=1)
REQ-033 Memory all 0xFFFFFF, enable=1 -> each plane has 32 panel_clk rising edges with panel_rgb=3'b111; total oe_n-low cycles per row = 255.
REQ-034 Only pixel (row 2, col 5)=0x800000 -> panel_rgb=3'b100 only at the 6th rising edge of plane 7 of row 2, then panel_addr=2; all other bits 0.
REQ-035 swap_req pulse mid-frame -> flip toggles 0->1 in the frame_done cycle of that frame; flip unchanged at the next frame end.
REQ-036 rst asserted during DISPLAY -> following cycle: panel_oe_n=1, panel_lat=0, panel_rgb=0, flip=0, state IDLE.
REQ-037 All pixels 0x101010 -> with DISPLAY_SCAN_GAMMA_EN, only plane 0 lit (value 1); without it, only plane 4 lit.
REQ-038 enable dropped mid-frame -> frame completes, frame_done pulses once, then IDLE with panel_oe_n=1 and no further panel_clk edges.
